// File: rtl/pulse_sync_pkg.sv
// Shared types and helpers for the multi-channel pulse synchroniser.
package pulse_sync_pkg;

  // Which accepted edges of the debounced level raise the sticky event flag.
  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_sel_e;

  // Counter width able to hold 0..debounce_cycles.
  function automatic int cnt_width(input int debounce_cycles);
    return $clog2(debounce_cycles + 1);
  endfunction

endpackage

// File: rtl/pulse_sync_channel.sv
// One channel: resynchroniser, consistency-count debounce, edge pulses and
// the sticky event / overflow flags with their acknowledge.
module pulse_sync_channel
  import pulse_sync_pkg::*;
#(
  parameter int        SYNC_STAGES     = 2,
  parameter int        DEBOUNCE_CYCLES = 16,
  parameter bit        ACTIVE_LOW      = 1'b0,
  parameter edge_sel_e EDGE_SEL        = EDGE_RISE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  input  logic ack_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic event_o,
  output logic overflow_o
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   event_q, event_d;
  logic                   overflow_q, overflow_d;
  logic                   sync_last;
  logic                   sel_edge;

  // Shift the polarity-corrected input into the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], raw_i ^ ACTIVE_LOW};
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

  // Accept a new level only after it has differed from the current one for
  // DEBOUNCE_CYCLES consecutive cycles; any return restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_last == level_q) begin
      cnt_d = {CW{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync_last;
      cnt_d   = {CW{1'b0}};
      rise_d  = sync_last;
      fall_d  = ~sync_last;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Decide whether the pulse currently shown is one that should flag an event.
  always_comb begin
    case (EDGE_SEL)
      EDGE_RISE: sel_edge = rise_q;
      EDGE_FALL: sel_edge = fall_q;
      EDGE_BOTH: sel_edge = rise_q | fall_q;
      default:   sel_edge = 1'b0;
    endcase
  end

  // Event / overflow handshake: a new selected edge always wins over an ack.
  always_comb begin
    event_d    = event_q;
    overflow_d = overflow_q;
    if (sel_edge) begin
      event_d = 1'b1;
      if (ack_i) begin
        overflow_d = 1'b0;
      end else if (event_q) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end else if (ack_i) begin
      event_d    = 1'b0;
      overflow_d = 1'b0;
    end else begin
      event_d    = event_q;
      overflow_d = overflow_q;
    end
  end

  // All channel state, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q     <= {SYNC_STAGES{1'b0}};
      cnt_q      <= {CW{1'b0}};
      level_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      event_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      event_q    <= event_d;
      overflow_q <= overflow_d;
    end
  end

  assign level_o    = level_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign event_o    = event_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/pulse_sync_array.sv
// Array of independent pulse synchroniser channels with parameter checks.
module pulse_sync_array
  import pulse_sync_pkg::*;
#(
  parameter int        CHANNELS        = 4,
  parameter int        SYNC_STAGES     = 2,
  parameter int        DEBOUNCE_CYCLES = 16,
  parameter bit        ACTIVE_LOW      = 1'b0,
  parameter edge_sel_e EDGE_SEL        = EDGE_RISE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] raw_i,
  input  logic [CHANNELS-1:0] ack_i,
  output logic [CHANNELS-1:0] level_o,
  output logic [CHANNELS-1:0] rise_o,
  output logic [CHANNELS-1:0] fall_o,
  output logic [CHANNELS-1:0] event_o,
  output logic [CHANNELS-1:0] overflow_o
);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("pulse_sync_array: SYNC_STAGES must be at least 2");
  end

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("pulse_sync_array: DEBOUNCE_CYCLES must be at least 1");
  end

  if (CHANNELS < 1) begin : g_bad_channels
    $error("pulse_sync_array: CHANNELS must be at least 1");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pulse_sync_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .EDGE_SEL       (EDGE_SEL)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw_i     (raw_i[i]),
      .ack_i     (ack_i[i]),
      .level_o   (level_o[i]),
      .rise_o    (rise_o[i]),
      .fall_o    (fall_o[i]),
      .event_o   (event_o[i]),
      .overflow_o(overflow_o[i])
    );
  end

endmodule

// File: tb/tb_pulse_sync_array.sv
// Randomised bench for pulse_sync_array with a history-window reference model.
module tb_pulse_sync_array;
  import pulse_sync_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] raw_a, ack_a, lvl_a, rise_a, fall_a, ev_a, ov_a;
  logic [1:0] raw_b, ack_b, lvl_b, rise_b, fall_b, ev_b, ov_b;
  logic [2:0] raw_c, ack_c, lvl_c, rise_c, fall_c, ev_c, ov_c;

  // A: defaults. B: boundary, inverted inputs, both edges. C: short debounce, fall edges.
  pulse_sync_array u_a (
    .clk(clk), .rst_n(rst_n), .raw_i(raw_a), .ack_i(ack_a), .level_o(lvl_a),
    .rise_o(rise_a), .fall_o(fall_a), .event_o(ev_a), .overflow_o(ov_a));

  pulse_sync_array #(.CHANNELS(2), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1),
                     .ACTIVE_LOW(1'b1), .EDGE_SEL(EDGE_BOTH)) u_b (
    .clk(clk), .rst_n(rst_n), .raw_i(raw_b), .ack_i(ack_b), .level_o(lvl_b),
    .rise_o(rise_b), .fall_o(fall_b), .event_o(ev_b), .overflow_o(ov_b));

  pulse_sync_array #(.CHANNELS(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(3),
                     .ACTIVE_LOW(1'b0), .EDGE_SEL(EDGE_FALL)) u_c (
    .clk(clk), .rst_n(rst_n), .raw_i(raw_c), .ack_i(ack_c), .level_o(lvl_c),
    .rise_o(rise_c), .fall_o(fall_c), .event_o(ev_c), .overflow_o(ov_c));

  int total = 0;
  int bad   = 0;

  int cfg_ch [3] = '{4, 2, 3};
  int cfg_s  [3] = '{2, 3, 2};
  int cfg_d  [3] = '{16, 1, 3};
  int cfg_al [3] = '{0, 1, 0};
  int cfg_es [3] = '{0, 2, 1};   // 0 rise, 1 fall, 2 both

  bit m_lvl  [3][4];
  bit m_rise [3][4];
  bit m_fall [3][4];
  bit m_ev   [3][4];
  bit m_ov   [3][4];
  bit hist   [3][4][40];         // polarity-corrected input samples, newest at 0

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: the level flips when the last D synchronised samples all
  // disagree with it; events follow the handshake rules on the previous pulses.
  task automatic model_step(input int d, input logic [3:0] raw, input logic [3:0] ack,
                            input logic rst_v);
    for (int ch = 0; ch < cfg_ch[d]; ch++) begin
      bit chg;
      bit sel;
      if (!rst_v) begin
        m_lvl[d][ch] = 1'b0; m_rise[d][ch] = 1'b0; m_fall[d][ch] = 1'b0;
        m_ev[d][ch]  = 1'b0; m_ov[d][ch]   = 1'b0;
        for (int k = 0; k < 40; k++) hist[d][ch][k] = 1'b0;
      end else begin
        chg = 1'b1;
        for (int k = 0; k < cfg_d[d]; k++)
          if (hist[d][ch][cfg_s[d] - 1 + k] == m_lvl[d][ch]) chg = 1'b0;
        sel = (cfg_es[d] == 0 && m_rise[d][ch]) || (cfg_es[d] == 1 && m_fall[d][ch]) ||
              (cfg_es[d] == 2 && (m_rise[d][ch] || m_fall[d][ch]));
        if (sel) begin
          if (ack[ch])          m_ov[d][ch] = 1'b0;
          else if (m_ev[d][ch]) m_ov[d][ch] = 1'b1;
          m_ev[d][ch] = 1'b1;
        end else if (ack[ch]) begin
          m_ev[d][ch] = 1'b0;
          m_ov[d][ch] = 1'b0;
        end
        m_rise[d][ch] = chg && !m_lvl[d][ch];
        m_fall[d][ch] = chg && m_lvl[d][ch];
        if (chg) m_lvl[d][ch] = !m_lvl[d][ch];
        for (int k = 39; k > 0; k--) hist[d][ch][k] = hist[d][ch][k-1];
        hist[d][ch][0] = raw[ch] ^ cfg_al[d][0];
      end
    end
  endtask

  task automatic cmp_dut(input int d, input string nm, input logic [3:0] lv, input logic [3:0] ri,
                         input logic [3:0] fa, input logic [3:0] ev, input logic [3:0] ov);
    logic [3:0] el, er, ef, ee, eo;
    el = 4'd0; er = 4'd0; ef = 4'd0; ee = 4'd0; eo = 4'd0;
    for (int ch = 0; ch < cfg_ch[d]; ch++) begin
      el[ch] = m_lvl[d][ch]; er[ch] = m_rise[d][ch]; ef[ch] = m_fall[d][ch];
      ee[ch] = m_ev[d][ch];  eo[ch] = m_ov[d][ch];
    end
    chk({nm, "_level"},    int'(lv), int'(el));
    chk({nm, "_rise"},     int'(ri), int'(er));
    chk({nm, "_fall"},     int'(fa), int'(ef));
    chk({nm, "_event"},    int'(ev), int'(ee));
    chk({nm, "_overflow"}, int'(ov), int'(eo));
  endtask

  // One clock: apply current inputs, advance the model, check all outputs.
  task automatic cycle(input logic r);
    rst_n = r;
    @(posedge clk);
    model_step(0, raw_a, ack_a, r);
    model_step(1, {2'b00, raw_b}, {2'b00, ack_b}, r);
    model_step(2, {1'b0, raw_c}, {1'b0, ack_c}, r);
    #1;
    cmp_dut(0, "a", lvl_a, rise_a, fall_a, ev_a, ov_a);
    cmp_dut(1, "b", {2'b00, lvl_b}, {2'b00, rise_b}, {2'b00, fall_b}, {2'b00, ev_b}, {2'b00, ov_b});
    cmp_dut(2, "c", {1'b0, lvl_c}, {1'b0, rise_c}, {1'b0, fall_c}, {1'b0, ev_c}, {1'b0, ov_c});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1);
  endtask

  int hold [9];
  bit val  [9];

  initial begin
    int first_rise, first_ev, n_rise, first_lvl_b, seen;
    raw_a = 4'd0; ack_a = 4'd0; raw_b = 2'b11; ack_b = 2'd0; raw_c = 3'd0; ack_c = 3'd0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0);
    chk("reset_outputs", int'({lvl_a, rise_a, fall_a, ev_a, ov_a}), 0);

    // Clean press on A[0]; simultaneous active-low press on boundary DUT B[0].
    raw_a[0] = 1'b1; raw_b[0] = 1'b0;
    first_rise = -1; first_ev = -1; n_rise = 0; first_lvl_b = -1;
    for (int e = 0; e < 25; e++) begin
      cycle(1'b1);
      if (rise_a[0]) begin n_rise++; if (first_rise < 0) first_rise = e; end
      if (ev_a[0] && first_ev < 0) first_ev = e;
      if (lvl_b[0] && first_lvl_b < 0) first_lvl_b = e;
    end
    chk("press_rise_edge", first_rise, 17);
    chk("press_event_edge", first_ev, 18);
    chk("press_rise_count", n_rise, 1);
    chk("boundary_level_edge", first_lvl_b, 3);

    // Reset mid-debounce with an event pending, input high through release.
    raw_a[0] = 1'b0;
    run(10);
    raw_a[0] = 1'b1;
    cycle(1'b0);
    chk("midreset_outputs", int'({lvl_a, rise_a, fall_a, ev_a, ov_a}), 0);
    first_rise = -1;
    for (int e = 0; e < 25; e++) begin
      cycle(1'b1);
      if (rise_a[0] && first_rise < 0) first_rise = e;
    end
    chk("fresh_rise_edge", first_rise, 17);

    // Overflow, rise coinciding with ack, then plain ack on A[2].
    raw_a[2] = 1'b1; run(25);
    raw_a[2] = 1'b0; run(25);
    raw_a[2] = 1'b1; run(25);
    chk("ovf_set", int'(ov_a[2]), 1);
    raw_a[2] = 1'b0; run(25);
    raw_a[2] = 1'b1;
    seen = 0;
    for (int e = 0; e < 30 && seen == 0; e++) begin
      cycle(1'b1);
      if (rise_a[2]) seen = 1;
    end
    chk("ovf_rise_seen", seen, 1);
    ack_a[2] = 1'b1; cycle(1'b1); ack_a[2] = 1'b0;
    chk("ack_coincide_event", int'(ev_a[2]), 1);
    chk("ack_coincide_ovf", int'(ov_a[2]), 0);
    ack_a[2] = 1'b1; cycle(1'b1); ack_a[2] = 1'b0;
    chk("ack_clear", int'({ev_a[2], ov_a[2]}), 0);

    // Randomised phase: mixed bouncy/steady inputs, random acks, rare resets.
    for (int i = 0; i < 9; i++) begin hold[i] = 0; val[i] = 1'b0; end
    val[4] = 1'b1; val[5] = 1'b1;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      for (int i = 0; i < 9; i++) begin
        if (hold[i] == 0) begin
          val[i]  = ~val[i];
          hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 40);
        end else begin
          hold[i]--;
        end
      end
      raw_a = {val[3], val[2], val[1], val[0]};
      raw_b = {val[5], val[4]};
      raw_c = {val[8], val[7], val[6]};
      for (int i = 0; i < 4; i++) ack_a[i] = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < 2; i++) ack_b[i] = ($urandom_range(0, 5) == 0);
      for (int i = 0; i < 3; i++) ack_c[i] = ($urandom_range(0, 5) == 0);
      cycle(($urandom_range(0, 599) != 0) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
